// File: rtl/sw_debounce.sv
// sw_debounce: synchronise, debounce and edge-detect N slide-switch inputs.
// Define SW_DEBOUNCE_EVCNT_EN to add per-channel 8-bit rise event counters.
module sw_debounce #(
  parameter int N = 2,
  parameter int DB_CYCLES = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_in,
  output logic [N-1:0] sw_out,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic         any_chg
`ifdef SW_DEBOUNCE_EVCNT_EN
  ,
  input  logic           evcnt_clr,
  output logic [N*8-1:0] evcnt
`endif
);
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);
  logic [SYNC_STAGES-1:0][N-1:0] sync_q;
  logic [N-1:0][CW-1:0] cnt_q, cnt_d;
  logic [N-1:0] sync, acc;
  logic [N-1:0] sw_out_q, sw_out_d, rise_q, rise_d, fall_q, fall_d;
  logic any_chg_q, any_chg_d;
  assign sync = sync_q[SYNC_STAGES-1];
  // a channel accepts its new level on the DB_CYCLES-th consecutive differing sample
  always_comb begin
    acc = '0;
    cnt_d = '0;
    for (int i = 0; i < N; i++) begin
      acc[i] = (sync[i] != sw_out_q[i]) && (cnt_q[i] == LAST);
      cnt_d[i] = (sync[i] != sw_out_q[i] && !acc[i]) ? cnt_q[i] + 1'b1 : '0;
    end
    sw_out_d = sw_out_q ^ acc;
    rise_d = acc & sync;
    fall_d = acc & ~sync;
    any_chg_d = |acc;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q <= '0;
      sw_out_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_chg_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw_in};
      cnt_q <= cnt_d;
      sw_out_q <= sw_out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_chg_q <= any_chg_d;
    end
  end
  assign sw_out = sw_out_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign any_chg = any_chg_q;
`ifdef SW_DEBOUNCE_EVCNT_EN
  logic [N-1:0][7:0] evcnt_q, evcnt_d;
  // counting the visible rise pulse lets a coincident clear keep that event
  always_comb begin
    evcnt_d = '0;
    for (int i = 0; i < N; i++)
      evcnt_d[i] = (evcnt_clr ? 8'd0 : evcnt_q[i]) + {7'd0, rise_q[i]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) evcnt_q <= '0;
    else evcnt_q <= evcnt_d;
  end
  assign evcnt = evcnt_q;
`endif
endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: randomized scoreboard bench for sw_debounce; the reference
// model accepts a level when the last DB sampled inputs all differ from the output.
module tb_sw_debounce;
  localparam int N = 2;
  localparam int DB = 16;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] sw_in = '0;
  logic [N-1:0] sw_out, rise, fall;
  logic any_chg;
`ifdef SW_DEBOUNCE_EVCNT_EN
  logic evcnt_clr = 1'b0;
  logic [N*8-1:0] evcnt;
  bit clr_en = 1'b0;
`endif
  typedef struct packed {
    logic [N-1:0] o;
    logic [N-1:0] r;
    logic [N-1:0] f;
    logic a;
`ifdef SW_DEBOUNCE_EVCNT_EN
    logic [N*8-1:0] ev;
`endif
  } exp_t;
  exp_t q[$];
  exp_t m, got;
  logic [N-1:0] hist[$];
  logic [N-1:0] out_m = '0;
`ifdef SW_DEBOUNCE_EVCNT_EN
  logic [N-1:0] rise_m = '0;
  logic [N-1:0][7:0] ev_m = '0;
`endif
  int checks = 0;
  int passes = 0;
  int cyc_n = 0;

  sw_debounce #(.N(N), .DB_CYCLES(DB), .SYNC_STAGES(SS)) dut (
    .clk(clk),
    .rst(rst),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .rise(rise),
    .fall(fall),
    .any_chg(any_chg)
`ifdef SW_DEBOUNCE_EVCNT_EN
    ,
    .evcnt_clr(evcnt_clr),
    .evcnt(evcnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model for one rising edge: the sample used at edge e is the input
  // captured SS edges earlier; reset edges record zeros.
  task automatic step(input logic r, input logic [N-1:0] s);
    exp_t x;
    int e;
    bit ok;
    logic [N-1:0] ri, fa;
    ri = '0;
    fa = '0;
    hist.push_back(r ? '0 : s);
    e = hist.size() - 1;
    if (r) out_m = '0;
    else
      for (int i = 0; i < N; i++) begin
        ok = e >= SS + DB - 1;
        if (ok)
          for (int k = e - SS - DB + 1; k <= e - SS; k++) ok &= (hist[k][i] != out_m[i]);
        if (ok) begin
          out_m[i] = ~out_m[i];
          ri[i] = out_m[i];
          fa[i] = ~out_m[i];
        end
      end
    x.o = out_m;
    x.r = ri;
    x.f = fa;
    x.a = |(ri | fa);
`ifdef SW_DEBOUNCE_EVCNT_EN
    for (int i = 0; i < N; i++)
      ev_m[i] = r ? 8'd0 : (evcnt_clr ? 8'd0 : ev_m[i]) + {7'd0, rise_m[i]};
    rise_m = ri;
    x.ev = ev_m;
`endif
    q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic [N-1:0] s);
    @(negedge clk);
    rst = r;
    sw_in = s;
`ifdef SW_DEBOUNCE_EVCNT_EN
    evcnt_clr = clr_en && ($urandom_range(0, 30) == 0);
`endif
    step(r, s);
  endtask

  task automatic chk(input string name, input logic [31:0] g, input logic [31:0] e);
    checks++;
    if (g === e) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, g, e);
  endtask

  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (q.size() > 0) begin
      m = q.pop_front();
      got.o = sw_out;
      got.r = rise;
      got.f = fall;
      got.a = any_chg;
`ifdef SW_DEBOUNCE_EVCNT_EN
      got.ev = evcnt;
`endif
      checks++;
      if (got === m) passes++;
      else $display("FAIL outputs cycle %0d: got o=%b r=%b f=%b a=%b (%h) expected o=%b r=%b f=%b a=%b (%h)",
                    cyc_n, got.o, got.r, got.f, got.a, got, m.o, m.r, m.f, m.a, m);
    end
  end

  initial begin
    int rem[N];
    logic [N-1:0] s;
    repeat (3) @(negedge clk);
    repeat (3) cyc(1'b1, '0);
    repeat (100) cyc(1'b0, 2'b00);
    repeat (30) cyc(1'b0, 2'b01);
    for (int t = 0; t < 200; t++) cyc(1'b0, ((t / 5) % 2 != 0) ? 2'b11 : 2'b01);
    repeat (30) cyc(1'b0, 2'b11);
    repeat (30) cyc(1'b0, 2'b00);
    repeat (30) cyc(1'b0, 2'b10);
    repeat (12) cyc(1'b0, 2'b11);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst sw_out", 32'(sw_out), 32'd0);
    chk("async rst pulses", 32'({rise, fall, any_chg}), 32'd0);
    repeat (3) cyc(1'b1, 2'b11);
    repeat (30) cyc(1'b0, 2'b11);
    s = 2'b11;
    for (int i = 0; i < N; i++) rem[i] = 1;
`ifdef SW_DEBOUNCE_EVCNT_EN
    clr_en = 1'b1;
`endif
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        rem[i]--;
        if (rem[i] == 0) begin
          s[i] = ~s[i];
          rem[i] = $urandom_range(1, 2 * DB + 8);
        end
      end
      if ($urandom_range(0, 599) == 0) repeat (SS + 1) cyc(1'b1, s);
      cyc(1'b0, s);
    end
    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
